// File: rtl/time_adjust_ctrl.sv
// ---------------------------------------------------------------------------
// time_adjust_ctrl
//
// Front-panel controller for a digital clock. Three raw pushbuttons are
// synchronized, debounced and turned into single-cycle press pulses. The
// pulses drive a five-state mode FSM that edits a working copy of the time
// (adj_hr/adj_min), loads it into the downstream counters with a one-cycle
// strobe, and edits the stored alarm time.
//
// Ports
//   clk                      single rising-edge clock
//   reset                    asynchronous, active-low reset
//   btn_mode/btn_up/btn_down raw asynchronous button levels, high = pressed
//   cur_min, cur_hr          live time from the downstream counters
//   mode                     RUN=0, SET_HR=1, SET_MIN=2, ALM_HR=3, ALM_MIN=4
//   adj_min, adj_hr          time value to load into the counters
//   ld_time                  one-cycle load strobe for the counters
//   run_en                   time counting permitted (gates seconds tick)
//   alm_min, alm_hr          stored alarm time
// ---------------------------------------------------------------------------
module time_adjust_ctrl #(
  parameter int DEB_CYC = 4,
  parameter int N_MIN   = 60,
  parameter int N_HR    = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [5:0] cur_min,
  input  logic [4:0] cur_hr,
  output logic [2:0] mode,
  output logic [5:0] adj_min,
  output logic [4:0] adj_hr,
  output logic       ld_time,
  output logic       run_en,
  output logic [5:0] alm_min,
  output logic [4:0] alm_hr
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    ALM_HR  = 3'd3,
    ALM_MIN = 3'd4
  } state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYC - 1);
  localparam logic [5:0] MIN_MAX  = 6'(N_MIN - 1);
  localparam logic [5:0] HR_MAX   = 6'(N_HR - 1);

  // Bit 0 = mode, bit 1 = up, bit 2 = down.
  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] deb;
  logic [2:0] press;
  logic [7:0] cnt [3];

  assign raw = {btn_down, btn_up, btn_mode};

  // -------------------------------------------------------------------------
  // Synchronizer + debounce + press pulse
  // The debounced level flips on the edge where the mismatch counter would
  // reach DEB_CYC; the press pulse is registered on that same edge so the
  // FSM reacts one edge later (DEB_CYC+3 edges after the raw rise).
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would collapse the synchronizer stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      press <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // reset like any other register.
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == DEB_LAST) begin
            deb[i]   <= ~deb[i];
            cnt[i]   <= '0;
            press[i] <= ~deb[i];   // only a 0->1 debounced edge is a press
          end else begin
            cnt[i] <= cnt[i] + 8'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Wrapping +/-1 step on a value held in 6 bits; max is modulus-1.
  function automatic logic [5:0] step_mod(input logic [5:0] v,
                                          input logic       inc,
                                          input logic [5:0] max);
    logic [5:0] r;
    // NOTE: every path assigns r first, so no latch-like hold is implied.
    r = v;
    if (inc) r = (v == max) ? 6'd0 : v + 6'd1;
    else     r = (v == 6'd0) ? max : v - 6'd1;
    return r;
  endfunction

  logic p_mode, p_up, p_dn;
  logic step_ok;

  assign p_mode  = press[0];
  assign p_up    = press[1];
  assign p_dn    = press[2];
  // A lone up or down press edits; both together cancel out.
  assign step_ok = p_up ^ p_dn;

  // -------------------------------------------------------------------------
  // Mode FSM with registered outputs. A mode press always wins over a
  // coincident up/down press.
  // -------------------------------------------------------------------------
  state_t state;

  assign mode = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      adj_min <= '0;
      adj_hr  <= '0;
      alm_min <= '0;
      alm_hr  <= '0;
      ld_time <= 1'b0;
      run_en  <= 1'b1;
    end else begin
      ld_time <= 1'b0;
      if (p_mode) begin
        case (state)
          RUN: begin
            adj_hr  <= cur_hr;
            adj_min <= cur_min;
            run_en  <= 1'b0;
            state   <= SET_HR;
          end
          SET_HR:  state <= SET_MIN;
          SET_MIN: begin
            // Counters load in the following cycle; adj_* stays untouched
            // until the next edit so the loaded value is stable.
            ld_time <= 1'b1;
            run_en  <= 1'b1;
            state   <= ALM_HR;
          end
          ALM_HR:  state <= ALM_MIN;
          ALM_MIN: state <= RUN;
          default: begin
            run_en <= 1'b1;
            state  <= RUN;
          end
        endcase
      end else if (step_ok) begin
        case (state)
          SET_HR:  adj_hr  <= 5'(step_mod({1'b0, adj_hr}, p_up, HR_MAX));
          SET_MIN: adj_min <= step_mod(adj_min, p_up, MIN_MAX);
          ALM_HR:  alm_hr  <= 5'(step_mod({1'b0, alm_hr}, p_up, HR_MAX));
          ALM_MIN: alm_min <= step_mod(alm_min, p_up, MIN_MAX);
          default: ;   // edits in RUN are ignored
        endcase
      end
    end
  end

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// ---------------------------------------------------------------------------
// tb_time_adjust_ctrl
//
// Self-checking bench for time_adjust_ctrl. Buttons are driven as clean
// presses (held at least DEB_CYC cycles, followed by a long idle gap) or as
// short glitches. A press-level reference model applies each accepted press
// to the abstract clock/alarm state using modular arithmetic.
// ---------------------------------------------------------------------------
module tb_time_adjust_ctrl;

  localparam int DEB = 4;
  localparam int NM  = 60;
  localparam int NH  = 24;
  localparam int GAP = DEB + 6;

  logic       clk;
  logic       reset;
  logic       btn_mode, btn_up, btn_down;
  logic [5:0] cur_min;
  logic [4:0] cur_hr;
  logic [2:0] mode;
  logic [5:0] adj_min;
  logic [4:0] adj_hr;
  logic       ld_time;
  logic       run_en;
  logic [5:0] alm_min;
  logic [4:0] alm_hr;

  time_adjust_ctrl #(.DEB_CYC(DEB), .N_MIN(NM), .N_HR(NH)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_mode(btn_mode),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .cur_min (cur_min),
    .cur_hr  (cur_hr),
    .mode    (mode),
    .adj_min (adj_min),
    .adj_hr  (adj_hr),
    .ld_time (ld_time),
    .run_en  (run_en),
    .alm_min (alm_min),
    .alm_hr  (alm_hr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: abstract panel state.
  int m_mode, m_adj_hr, m_adj_min, m_alm_hr, m_alm_min;
  int ld_expected, ld_seen, ld_hr_exp, ld_min_exp;

  task automatic model_reset();
    m_mode = 0; m_adj_hr = 0; m_adj_min = 0; m_alm_hr = 0; m_alm_min = 0;
  endtask

  task automatic model_press(input bit pm, input bit pu, input bit pd);
    int d;
    if (pm) begin
      if (m_mode == 0) begin
        m_adj_hr  = int'(cur_hr);
        m_adj_min = int'(cur_min);
      end else if (m_mode == 2) begin
        ld_expected++;
        ld_hr_exp  = m_adj_hr;
        ld_min_exp = m_adj_min;
      end
      m_mode = (m_mode + 1) % 5;
    end else if (pu != pd) begin
      d = pu ? 1 : -1;
      case (m_mode)
        1: m_adj_hr  = (m_adj_hr  + d + NH) % NH;
        2: m_adj_min = (m_adj_min + d + NM) % NM;
        3: m_alm_hr  = (m_alm_hr  + d + NH) % NH;
        4: m_alm_min = (m_alm_min + d + NM) % NM;
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".mode"},    int'(mode),    m_mode);
    check({tag, ".adj_hr"},  int'(adj_hr),  m_adj_hr);
    check({tag, ".adj_min"}, int'(adj_min), m_adj_min);
    check({tag, ".alm_hr"},  int'(alm_hr),  m_alm_hr);
    check({tag, ".alm_min"}, int'(alm_min), m_alm_min);
    check({tag, ".run_en"},  int'(run_en),  (m_mode == 1 || m_mode == 2) ? 0 : 1);
    check({tag, ".ld_cnt"},  ld_seen,       ld_expected);
  endtask

  // Every ld_time cycle is counted and must carry the edited time.
  always @(negedge clk) begin
    if (ld_time === 1'b1) begin
      ld_seen++;
      check("ld.adj_hr",  int'(adj_hr),  ld_hr_exp);
      check("ld.adj_min", int'(adj_min), ld_min_exp);
      check("ld.mode",    int'(mode),    3);
      check("ld.run_en",  int'(run_en),  1);
    end
  end

  // Clean press: all selected buttons rise together, held for `hold` edges.
  task automatic press(input bit pm, input bit pu, input bit pd, input int hold);
    model_press(pm, pu, pd);
    @(negedge clk);
    btn_mode = pm; btn_up = pu; btn_down = pd;
    repeat (hold) @(negedge clk);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  // Short pulse that must be rejected by the debouncer.
  task automatic glitch(input bit pm, input bit pu, input bit pd, input int len);
    @(negedge clk);
    btn_mode = pm; btn_up = pu; btn_down = pd;
    repeat (len) @(negedge clk);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic mode_press();
    if (m_mode == 0) begin
      cur_hr  = 5'($urandom_range(NH - 1));
      cur_min = 6'($urandom_range(NM - 1));
    end
    press(1'b1, 1'b0, 1'b0, DEB);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bit bu;
    reset = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    cur_hr = 5'd13; cur_min = 6'd45;
    ld_expected = 0; ld_seen = 0; ld_hr_exp = 0; ld_min_exp = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Mode press from RUN: transition exactly on edge DEB+3 after the rise.
    model_press(1'b1, 1'b0, 1'b0);
    btn_mode = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == DEB + 2) check("lat.before", int'(mode), 0);
      if (k == DEB + 3) check("lat.at",     int'(mode), 1);
    end
    @(negedge clk);
    btn_mode = 1'b0;
    repeat (GAP) @(negedge clk);
    check_all("to_set_hr");

    // Hour wrap both ways.
    repeat (10) press(1'b0, 1'b1, 1'b0, DEB);
    check_all("hr23");
    press(1'b0, 1'b1, 1'b0, DEB + 1);
    check_all("hr_wrap_up");
    press(1'b0, 1'b0, 1'b1, DEB);
    check_all("hr_wrap_dn");

    // Rejected inputs.
    glitch(1'b0, 1'b1, 1'b0, DEB - 1);
    check_all("glitch");
    press(1'b0, 1'b1, 1'b1, DEB);
    check_all("up_dn_same");
    press(1'b1, 1'b1, 1'b0, DEB);
    check_all("mode_wins");

    // Load, then alarm 06:30.
    press(1'b1, 1'b0, 1'b0, DEB);
    check_all("to_alm_hr");
    repeat (6) press(1'b0, 1'b1, 1'b0, DEB);
    press(1'b1, 1'b0, 1'b0, DEB);
    repeat (30) press(1'b0, 1'b1, 1'b0, DEB);
    check_all("alarm_0630");
    press(1'b1, 1'b0, 1'b0, DEB);
    check_all("back_run");
    press(1'b0, 1'b1, 1'b0, DEB);
    check_all("run_ignores_up");

    // Minute wrap down from 0.
    cur_hr = 5'd7; cur_min = 6'd0;
    press(1'b1, 1'b0, 1'b0, DEB);
    press(1'b1, 1'b0, 1'b0, DEB);
    press(1'b0, 1'b0, 1'b1, DEB);
    check_all("min_wrap_dn");
    press(1'b1, 1'b0, 1'b0, DEB);
    press(1'b1, 1'b0, 1'b0, DEB);
    check_all("alm_min_state");

    // Reset in ALM_MIN clears everything, no load strobe.
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (GAP) @(negedge clk);
    check_all("post_reset");

    // Button already held across reset release counts as a fresh press.
    @(negedge clk);
    reset = 1'b0;
    btn_mode = 1'b1;
    cur_hr = 5'd22; cur_min = 6'd59;
    repeat (3) @(negedge clk);
    model_press(1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    btn_mode = 1'b0;
    repeat (GAP) @(negedge clk);
    check_all("held_over_reset");

    // Randomized press sequence.
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(9);
      bu = 1'($urandom_range(1));
      case (r)
        0, 1, 2: mode_press();
        3, 4:    press(1'b0, 1'b1, 1'b0, DEB + $urandom_range(5));
        5, 6:    press(1'b0, 1'b0, 1'b1, DEB + $urandom_range(5));
        7:       press(1'b0, 1'b1, 1'b1, DEB + $urandom_range(3));
        8: begin
          if (m_mode == 0) begin
            cur_hr  = 5'($urandom_range(NH - 1));
            cur_min = 6'($urandom_range(NM - 1));
          end
          press(1'b1, bu, ~bu, DEB + $urandom_range(3));
        end
        default: glitch(1'($urandom_range(1)), bu, ~bu, $urandom_range(1, DEB - 1));
      endcase
      check_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
